// File: rtl/falu_result_buffer.sv
// falu_result_buffer: first-word-fall-through result FIFO behind the falu
// combinational ALU. It stores each result word, its opcode and its
// overflow/underflow bits, tags the head entry with an IEEE-754 class, and
// presents the entry over a valid/ready handshake.
// Optional feature macro: FALU_STICKY_FLAGS_EN (sticky exception flags).
// When the macro is undefined, sticky_ovf and sticky_unf are tied low and
// flag_clr is ignored.
module falu_result_buffer #(
  parameter int WIDTH    = 32,
  parameter int MANTISSA = 23,
  parameter int EXP_BITS = WIDTH - MANTISSA - 1,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [2:0]                 in_sel,
  input  logic                       in_overflow,
  input  logic                       in_underflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [2:0]                 out_sel,
  output logic                       out_overflow,
  output logic                       out_underflow,
  output logic [1:0]                 out_class,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       flag_clr,
  output logic                       sticky_ovf,
  output logic                       sticky_unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  // Entry layout: {result, sel, overflow, underflow}
  localparam int EW = WIDTH + 5;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [EW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [LW-1:0]       count;
  logic                push;
  logic                pop;
  logic [EW-1:0]       head;
  logic [EXP_BITS-1:0] head_exp;
  logic [MANTISSA-1:0] head_man;

  // Handshake qualifiers. in_ready depends only on the registered count, so a
  // pop in the same cycle cannot open a slot for a push while full.
  assign in_ready  = (count != LEVEL_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;

  // Storage write; the array is not reset, and writes are suppressed in reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wptr] <= {in_result, in_sel, in_overflow, in_underflow};
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields fall through from storage, forced to zero while empty.
  always_comb begin
    head          = mem[rptr];
    out_result    = '0;
    out_sel       = '0;
    out_overflow  = 1'b0;
    out_underflow = 1'b0;
    if (out_valid) begin
      out_result    = head[EW-1:5];
      out_sel       = head[4:2];
      out_overflow  = head[1];
      out_underflow = head[0];
    end
  end

  // Classify the head word (sign ignored); an empty FIFO presents a zero
  // word, which classifies as zero.
  always_comb begin
    head_exp = out_result[WIDTH-2:MANTISSA];
    head_man = out_result[MANTISSA-1:0];
    if (head_exp == '1) begin
      out_class = 2'b11;
    end else if (head_exp == '0) begin
      out_class = (head_man == '0) ? 2'b00 : 2'b10;
    end else begin
      out_class = 2'b01;
    end
  end

`ifdef FALU_STICKY_FLAGS_EN
  // Sticky exception flags: a set on an accepted push beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      if (push && in_overflow) begin
        sticky_ovf <= 1'b1;
      end else if (flag_clr) begin
        sticky_ovf <= 1'b0;
      end
      if (push && in_underflow) begin
        sticky_unf <= 1'b1;
      end else if (flag_clr) begin
        sticky_unf <= 1'b0;
      end
    end
  end
`else
  logic unused_flag_clr;

  assign unused_flag_clr = flag_clr;
  assign sticky_ovf      = 1'b0;
  assign sticky_unf      = 1'b0;
`endif

endmodule
